// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - circular-buffer instruction fetch queue between fetch and decode (optional FETCHQ_BYPASS_EN)
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [XLEN-1:0]          enq_pc,
  input  logic [XLEN-1:0]          enq_inst,
  input  logic                     enq_fault,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [XLEN-1:0]          deq_pc,
  output logic [XLEN-1:0]          deq_inst,
  output logic                     deq_fault,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]     FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]     ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PONE = AW'(1);
  localparam logic [XLEN-1:0] NOP  = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [XLEN-1:0] r_inst  [DEPTH];
  logic            r_fault [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [AW:0]     r_count;

  logic            w_stored_valid;
  logic            w_bypass;
  logic            w_wr;
  logic            w_rd;
  logic [XLEN-1:0] w_sel_pc;
  logic [XLEN-1:0] w_sel_inst;
  logic            w_sel_fault;

  assign count          = r_count;
  // enq_ready deliberately ignores deq_ready: a full queue never accepts, even while draining
  assign enq_ready      = (r_count < FULL) && !flush;
  assign w_stored_valid = (r_count != '0) && !flush;

`ifdef FETCHQ_BYPASS_EN
  // rst_n gates the bypass so deq_valid stays low throughout reset
  assign w_bypass = rst_n && (r_count == '0) && enq_valid && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign deq_valid   = w_stored_valid || w_bypass;
  assign w_sel_pc    = w_bypass ? enq_pc    : r_pc[r_head];
  assign w_sel_inst  = w_bypass ? enq_inst  : r_inst[r_head];
  assign w_sel_fault = w_bypass ? enq_fault : r_fault[r_head];
  assign deq_pc      = w_sel_pc;
  assign deq_fault   = w_sel_fault;
  // Faulted fetches present a NOP so decode does not also flag an illegal instruction
  assign deq_inst    = w_sel_fault ? NOP : w_sel_inst;

  // A bypassed instruction consumed in the same cycle is never written; it only reads from storage when not bypassing
  assign w_wr = enq_valid && enq_ready && !(w_bypass && deq_ready);
  assign w_rd = deq_valid && deq_ready && !flush && !w_bypass;

  // Pointer and occupancy update; flush wins over any concurrent traffic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_tail <= r_tail + PONE;
      if (w_rd) r_head <= r_head + PONE;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + ONE;
        2'b01:   r_count <= r_count - ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage, cleared on reset so the head reads zero while rst_n is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_inst[i]  <= '0;
        r_fault[i] <= 1'b0;
      end
    end else if (w_wr) begin
      r_pc[r_tail]    <= enq_pc;
      r_inst[r_tail]  <= enq_inst;
      r_fault[r_tail] <= enq_fault;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - scoreboard testbench for inst_fetch_queue with queue-based reference model
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            enq_valid;
  logic            enq_ready;
  logic [XLEN-1:0] enq_pc;
  logic [XLEN-1:0] enq_inst;
  logic            enq_fault;
  logic            deq_valid;
  logic            deq_ready;
  logic [XLEN-1:0] deq_pc;
  logic [XLEN-1:0] deq_inst;
  logic            deq_fault;
  logic [CW-1:0]   count;

  inst_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_pc(enq_pc), .enq_inst(enq_inst), .enq_fault(enq_fault),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_inst(deq_inst), .deq_fault(deq_fault),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } entry_t;

  typedef struct {
    int          cnt;
    bit          rdy;
    bit          vld;
    logic [31:0] pc;
    logic [31:0] inst;
    bit          fault;
  } exp_t;

  entry_t model_q[$];
  exp_t   sb[$];
  int     total = 0;
  int     bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, push the expected response, advance the model
  task automatic step(input bit fl, input bit ev, input logic [31:0] pc,
                      input logic [31:0] inst, input bit flt, input bit dr);
    exp_t   e;
    entry_t in;
    entry_t hd;
    int     sz;
    bit     byp;
    @(posedge clk);
    #1;
    flush = fl; enq_valid = ev; enq_pc = pc; enq_inst = inst; enq_fault = flt; deq_ready = dr;
    #1;
    in.pc = pc; in.inst = inst; in.fault = flt;
    sz  = model_q.size();
    byp = BYP && (sz == 0) && ev && !fl;
    e.cnt = sz;
    e.rdy = (sz < DEPTH) && !fl;
    e.vld = ((sz != 0) && !fl) || byp;
    if (byp) hd = in;
    else if (sz != 0) hd = model_q[0];
    else begin hd.pc = '0; hd.inst = '0; hd.fault = 1'b0; end
    e.pc    = hd.pc;
    e.fault = hd.fault;
    e.inst  = hd.fault ? 32'h0000_0013 : hd.inst;
    sb.push_back(e);
    if (fl) model_q.delete();
    else if (!(byp && dr)) begin
      if (e.vld && dr) void'(model_q.pop_front());
      if (ev && e.rdy) model_q.push_back(in);
    end
  endtask

  task automatic check_reset_outputs(input bit fl_exp);
    check("rst_count",     32'(count),     32'd0);
    check("rst_deq_valid", 32'(deq_valid), 32'd0);
    check("rst_deq_pc",    deq_pc,         32'd0);
    check("rst_deq_inst",  deq_inst,       32'd0);
    check("rst_deq_fault", 32'(deq_fault), 32'd0);
    check("rst_enq_ready", 32'(enq_ready), 32'(!fl_exp));
  endtask

  // Monitor: pop one expectation per cycle and compare away from the rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("count",     32'(count),     32'(e.cnt));
        check("enq_ready", 32'(enq_ready), 32'(e.rdy));
        check("deq_valid", 32'(deq_valid), 32'(e.vld));
        if (e.vld) begin
          check("deq_pc",    deq_pc,         e.pc);
          check("deq_inst",  deq_inst,       e.inst);
          check("deq_fault", 32'(deq_fault), 32'(e.fault));
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    rst_n = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    enq_pc = '0; enq_inst = '0; enq_fault = 1'b0;
    #3;
    check_reset_outputs(1'b0);
    @(posedge clk); #3; rst_n = 1'b1;

    // Fill to DEPTH, then a refused fifth enqueue
    for (int i = 0; i < 4; i++) step(0, 1, 32'(i*4), 32'h1000 + 32'(i), 0, 0);
    step(0, 1, 32'h10, 32'h2000, 0, 0);
    // Full with simultaneous enqueue and dequeue: head leaves, enqueue refused
    step(0, 1, 32'h10, 32'h2001, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    // Flush with count=3 and an enqueue in the same cycle
    step(1, 1, 32'h50, 32'h3000, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // Wrap: ten streamed enqueues
    for (int i = 0; i < 10; i++) step(0, 1, 32'(i*4), 32'h4000 + 32'(i), 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    // Faulted fetch shows a NOP
    step(0, 1, 32'h100, 32'hFFFF_FFFF, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    // Empty queue with enq_valid and deq_ready (bypass when enabled)
    step(0, 1, 32'h200, 32'h5000, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7), $urandom,
           $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 6));
    end

    // Asynchronous mid-stream reset, applied between edges
    for (int i = 0; i < 3; i++) step(0, 1, 32'h300 + 32'(i*4), 32'h6000, 0, 0);
    @(negedge clk); #1;
    flush = 1'b0; enq_valid = 1'b1; enq_pc = 32'hABC; enq_inst = 32'h7; deq_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(1'b0);
    flush = 1'b1;
    #1;
    check("rst_enq_ready_flush", 32'(enq_ready), 32'd0);
    flush = 1'b0; enq_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    model_q.delete();
    // First enqueue after reset comes out first
    step(0, 1, 32'h400, 32'h7000, 0, 0);
    step(0, 1, 32'h404, 32'h7001, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter XLEN, default 32, width of PC and instruction fields.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 flush  input  1  redirect or fence.i; SHALL discard every queued entry.
REQ-006 enq_valid  input  1  fetch side presents an instruction.
REQ-007 enq_ready  output  1  queue accepts an enqueue this cycle.
REQ-008 enq_pc  input  XLEN  PC of the fetched instruction.
REQ-009 enq_inst  input  XLEN  raw instruction word.
REQ-010 enq_fault  input  1  instruction access fault for this fetch.
REQ-011 deq_valid  output  1  head entry is valid for the decode stage.
REQ-012 deq_ready  input  1  decode stage consumes the head this cycle.
REQ-013 deq_pc  output  XLEN  PC of the head entry.
REQ-014 deq_inst  output  XLEN  instruction word of the head entry, fed to the control unit.
REQ-015 deq_fault  output  1  access-fault flag of the head entry.
REQ-016 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-017 An enqueue SHALL occur when enq_valid && enq_ready && !flush.
REQ-018 A dequeue SHALL occur when deq_valid && deq_ready && !flush.
REQ-019 enq_ready SHALL equal (count < DEPTH) && !flush. It SHALL NOT depend on deq_ready, so a full queue refuses an enqueue even while it dequeues in the same cycle.
REQ-020 deq_valid SHALL equal (count != 0) && !flush. Bypass is covered in REQ-029.
REQ-021 Storage SHALL be a circular buffer. Head and tail pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-022 A simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-023 When flush is asserted, count, head and tail SHALL be 0 on the next edge. Flush SHALL take priority over any simultaneous enqueue or dequeue.
REQ-024 Entries SHALL leave in enqueue order. Latency from enqueue to deq_valid SHALL be one cycle.
REQ-025 When the head entry has fault=1, deq_inst SHALL read 0x00000013 (NOP) and deq_pc/deq_fault SHALL carry the stored values. This keeps the decoder's illegal-instruction flag clear for faulted fetches.
REQ-026 count SHALL never exceed DEPTH and SHALL never underflow below 0.

Reset
REQ-027 While rst_n=0, the following SHALL hold immediately, independent of clk:
- count=0, head=0, tail=0
- every stored pc, inst and fault = 0
- deq_valid=0, deq_pc=0, deq_inst=0, deq_fault=0
- enq_ready=1 (enq_ready=0 if flush is also asserted)
REQ-028 Asserting reset mid-stream SHALL discard all entries. The first enqueue after rst_n rises SHALL land in entry 0.

Configuration
REQ-029 With macro FETCHQ_BYPASS_EN defined:
- when count=0 and enq_valid=1 and flush=0, deq_valid SHALL be 1 in the same cycle, and deq_pc/deq_inst/deq_fault SHALL show the enq_* values (NOP substitution still applies).
- if deq_ready=1 in that cycle, the instruction SHALL be consumed without being written, and count SHALL stay 0.
- if deq_ready=0, the instruction SHALL be written normally.
REQ-030 Without FETCHQ_BYPASS_EN, the bypass path SHALL be absent and REQ-024 latency applies unconditionally.

Verification
REQ-031 Fill: DEPTH=4, deq_ready=0, enqueue PCs 0x0,0x4,0x8,0xC -> count=4, enq_ready=0. A fifth enqueue of PC 0x10 is refused.
REQ-032 Full with simultaneous traffic: count=4, enq_valid=1, deq_ready=1 for one cycle -> PC 0x0 leaves, enqueue is refused, count=3.
REQ-033 Wrap: 10 enqueues with deq_ready=1 streaming -> deq_pc sequence 0x0..0x24 in order, with no gaps after pointer wrap.
REQ-034 Flush: count=3, flush=1 with enq_valid=1 -> deq_valid=0 in that cycle. Next cycle count=0 and the flush-cycle instruction is absent.
REQ-035 Fault: enqueue pc=0x100, inst=0xFFFFFFFF, fault=1 -> deq_inst=0x00000013, deq_fault=1, deq_pc=0x100.
REQ-036 Reset and bypass:
- rst_n pulsed low mid-stream, asynchronously to clk -> outputs take reset values immediately.
- with FETCHQ_BYPASS_EN, empty queue, enq_valid=1, deq_ready=1 -> deq_valid=1 in the same cycle and count remains 0.
